// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register pending scoreboard,
// a popcount-tracking pending counter and optional write-to-read bypass.
module regfile_sb #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
   parameter int unsigned NUM_RD   = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             WriteReg,
   input  logic [ADDR_W-1:0]                DstReg,
   input  logic [DATA_W-1:0]                DstData,
   input  logic                             IssueEn,
   input  logic [ADDR_W-1:0]                IssueReg,
   input  logic [NUM_RD*ADDR_W-1:0]         SrcReg,
   output logic [NUM_RD*DATA_W-1:0]         SrcData,
   output logic [NUM_RD-1:0]                SrcReady,
   output logic [$clog2(NUM_REGS+1)-1:0]    PendCount
);

   localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] pend_q, pend_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_c, iss_c, inc_c, dec_c;

   // Effective write/issue after zero-register masking; issue beats write on a shared index.
   always_comb begin
      wr_c   = WriteReg && !(ZERO_REG && (DstReg == '0));
      iss_c  = IssueEn && !(ZERO_REG && (IssueReg == '0));
      inc_c  = iss_c && !pend_q[IssueReg];
      dec_c  = wr_c && pend_q[DstReg] && !(iss_c && (IssueReg == DstReg));
      pend_d = pend_q;
      if (wr_c) begin
         pend_d[DstReg] = 1'b0;
      end
      if (iss_c) begin
         pend_d[IssueReg] = 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(inc_c) - CNT_W'(dec_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_c) begin
            regs_q[DstReg] <= DstData;
         end
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign PendCount = cnt_q;

   // Read ports: zero register, then forwarded write, then stored state.
   always_comb begin
      logic [ADDR_W-1:0] src;
      SrcData  = '0;
      SrcReady = '0;
      src      = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         src = SrcReg[p*ADDR_W +: ADDR_W];
         if (ZERO_REG && (src == '0)) begin
            SrcData[p*DATA_W +: DATA_W] = '0;
            SrcReady[p]                 = 1'b1;
         end else if (BYPASS && WriteReg && !rst && (DstReg == src)) begin
            SrcData[p*DATA_W +: DATA_W] = DstData;
            SrcReady[p]                 = 1'b1;
         end else begin
            SrcData[p*DATA_W +: DATA_W] = regs_q[src];
            SrcReady[p]                 = !pend_q[src];
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic against a
// behavioural model, run on a bypass instance and a non-bypass instance.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst, wr, iss;
   logic [3:0]  dst, ireg;
   logic [15:0] din;
   logic [7:0]  src;
   logic [31:0] sd_b, sd_n;
   logic [1:0]  sr_b, sr_n;
   logic [4:0]  pc_b, pc_n;

   int n_checks = 0;
   int n_fail   = 0;

   bit [15:0] m_regs [16];
   bit        m_pend [16];
   bit        m_valid = 1'b0;

   always #5 clk = ~clk;

   regfile_sb #(.BYPASS(1'b1)) u_byp (
      .clk(clk), .rst(rst), .WriteReg(wr), .DstReg(dst), .DstData(din),
      .IssueEn(iss), .IssueReg(ireg), .SrcReg(src),
      .SrcData(sd_b), .SrcReady(sr_b), .PendCount(pc_b));

   regfile_sb #(.BYPASS(1'b0)) u_nbyp (
      .clk(clk), .rst(rst), .WriteReg(wr), .DstReg(dst), .DstData(din),
      .IssueEn(iss), .IssueReg(ireg), .SrcReg(src),
      .SrcData(sd_n), .SrcReady(sr_n), .PendCount(pc_n));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_data(input logic [3:0] s, input bit byp);
      if (s == 4'd0) return 16'h0;
      if (byp && wr && !rst && dst == s) return din;
      return m_regs[s];
   endfunction

   function automatic logic exp_rdy(input logic [3:0] s, input bit byp);
      if (s == 4'd0) return 1'b1;
      if (byp && wr && !rst && dst == s) return 1'b1;
      return !m_pend[s];
   endfunction

   function automatic logic [4:0] exp_cnt();
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m_pend[i]);
      return 5'(n);
   endfunction

   task automatic drive(input logic r, input logic w, input logic [3:0] d, input logic [15:0] dd,
                        input logic is, input logic [3:0] ir, input logic [3:0] s1, input logic [3:0] s0);
      rst = r; wr = w; dst = d; din = dd; iss = is; ireg = ir; src = {s1, s0};
   endtask

   // Mid-cycle sample: every port of both instances against the model.
   task automatic sample();
      logic [3:0] s;
      @(negedge clk);
      if (m_valid) begin
         for (int p = 0; p < 2; p++) begin
            s = src[p*4 +: 4];
            chk($sformatf("byp_data%0d", p), 32'(sd_b[p*16 +: 16]), 32'(exp_data(s, 1'b1)));
            chk($sformatf("byp_rdy%0d", p),  32'(sr_b[p]),          32'(exp_rdy(s, 1'b1)));
            chk($sformatf("nbyp_data%0d", p), 32'(sd_n[p*16 +: 16]), 32'(exp_data(s, 1'b0)));
            chk($sformatf("nbyp_rdy%0d", p),  32'(sr_n[p]),          32'(exp_rdy(s, 1'b0)));
         end
         chk("byp_cnt",  32'(pc_b), 32'(exp_cnt()));
         chk("nbyp_cnt", 32'(pc_n), 32'(exp_cnt()));
      end
   endtask

   // Clock edge: apply the architectural rules to the model.
   task automatic adv();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
         end
         m_valid = 1'b1;
      end else begin
         if (wr && dst != 4'd0) begin
            m_regs[dst] = din;
            m_pend[dst] = 1'b0;
         end
         if (iss && ireg != 4'd0) m_pend[ireg] = 1'b1;
      end
      #1;
   endtask

   task automatic step();
      sample();
      adv();
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 5, 0);
      step(); step();

      // Reset state
      drive(0, 0, 0, 0, 0, 0, 5, 0);
      sample();
      chk("rst_data", sd_b, 32'h0);
      chk("rst_rdy", 32'(sr_b), 32'h3);
      chk("rst_cnt", 32'(pc_b), 32'h0);
      adv();

      // Write with same-cycle read
      drive(0, 1, 3, 16'hBEEF, 0, 0, 5, 3);
      sample();
      chk("wr_byp", 32'(sd_b[15:0]), 32'hBEEF);
      chk("wr_nbyp_old", 32'(sd_n[15:0]), 32'h0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 5, 3);
      sample();
      chk("wr_after_byp", 32'(sd_b[15:0]), 32'hBEEF);
      chk("wr_after_nbyp", 32'(sd_n[15:0]), 32'hBEEF);
      adv();

      // Scoreboard issue / writeback
      drive(0, 0, 0, 0, 1, 7, 7, 0); step();
      drive(0, 0, 0, 0, 0, 0, 7, 0);
      sample();
      chk("iss_rdy", 32'(sr_b[1]), 32'h0);
      chk("iss_cnt", 32'(pc_b), 32'h1);
      adv();
      drive(0, 1, 7, 16'h1234, 0, 0, 7, 0);
      sample();
      chk("wb_byp_rdy", 32'(sr_b[1]), 32'h1);
      chk("wb_byp_data", 32'(sd_b[31:16]), 32'h1234);
      chk("wb_nbyp_rdy", 32'(sr_n[1]), 32'h0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 7, 0);
      sample();
      chk("wb_cnt", 32'(pc_b), 32'h0);
      adv();

      // Write and issue on the same index
      drive(0, 1, 4, 16'h00AA, 1, 4, 0, 4); step();
      drive(0, 0, 0, 0, 0, 0, 0, 4);
      sample();
      chk("wi_data", 32'(sd_b[15:0]), 32'h00AA);
      chk("wi_rdy", 32'(sr_b[0]), 32'h0);
      chk("wi_cnt", 32'(pc_b), 32'h1);
      adv();
      drive(0, 0, 0, 0, 1, 2, 9, 2); step();
      drive(0, 1, 2, 16'h2222, 1, 9, 9, 2); step();
      drive(0, 0, 0, 0, 0, 0, 9, 2);
      sample();
      chk("swap_cnt", 32'(pc_b), 32'h2);
      adv();

      // Zero register ignores writes and issues
      drive(0, 1, 0, 16'hFFFF, 1, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      chk("zero_data", sd_b, 32'h0);
      chk("zero_rdy", 32'(sr_b), 32'h3);
      chk("zero_cnt", 32'(pc_b), 32'h2);
      adv();

      // Reset mid-operation
      drive(1, 0, 0, 0, 0, 0, 0, 0); step();
      for (int r = 1; r <= 3; r++) begin
         drive(0, 0, 0, 0, 1, 4'(r), 0, 0); step();
      end
      drive(0, 0, 0, 0, 0, 0, 2, 1);
      sample();
      chk("pre_rst_cnt", 32'(pc_b), 32'h3);
      adv();
      drive(1, 1, 5, 16'h5555, 0, 0, 1, 5);
      sample();
      chk("rst_nobyp", 32'(sd_b[15:0]), 32'h0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 1, 5);
      sample();
      chk("mid_rst_data", sd_b, 32'h0);
      chk("mid_rst_rdy", 32'(sr_b), 32'h3);
      chk("mid_rst_cnt", 32'(pc_b), 32'h0);
      adv();

      // Random traffic
      for (int c = 0; c < 500; c++) begin
         logic [3:0] d, s0, s1;
         d  = 4'($urandom_range(0, 15));
         s0 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
         s1 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
         drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), d, 16'($urandom),
               ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), s1, s0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
